// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side blocks.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: finds the first set request bit
// searching upward from last_id+1 and wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_id,
    output logic                       any,
    output logic [$clog2(NUM_REQ)-1:0] id
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] cand;

    // Walk the candidates in priority order, keeping the first one that is requesting
    always_comb begin
        any  = 1'b0;
        id   = '0;
        cand = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_id) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any = 1'b1;
                id  = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing the UART TX FIFO write port
// among NUM_REQ byte-stream requesters, with a stall watchdog.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int TIMEOUT_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           wena,
    output logic [UART_BYTE_W-1:0]         wdata,
    input  logic                           full,
    output logic                           grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           timeout
);

    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_t               state;
    logic [ID_W-1:0]          last_id;
    logic [TIMEOUT_WIDTH-1:0] wd_cnt;

    logic                     pick_any;
    logic [ID_W-1:0]          pick_id;

    logic [UART_BYTE_W-1:0]   req_bytes [NUM_REQ];
    logic                     sel_valid;
    logic                     sel_last;
    logic                     handshake;
    logic                     wd_tick;
    logic                     wd_expired;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req_valid),
        .last_id (last_id),
        .any     (pick_any),
        .id      (pick_id)
    );

    // Split the flat data bus into one byte per requester for clean indexing
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*UART_BYTE_W +: UART_BYTE_W];
        end
    end

    // Write-port mux driven straight from the registered grant, so the first byte can go out in the first XFER cycle
    always_comb begin
        sel_valid  = req_valid[grant_id];
        sel_last   = req_last[grant_id];
        handshake  = grant_valid && sel_valid && !full;
        wd_tick    = grant_valid && !sel_valid && !full;
        wd_expired = &wd_cnt;
        wena       = handshake;
        wdata      = grant_valid ? req_bytes[grant_id] : '0;
        req_ready  = '0;
        if (grant_valid && !full) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Arbitration FSM, grant registers and watchdog; a handshake always beats watchdog expiry and a full FIFO freezes the watchdog
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last_id     <= ID_W'(NUM_REQ - 1);
            wd_cnt      <= '0;
            timeout     <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            last_id     <= ID_W'(NUM_REQ - 1);
            wd_cnt      <= '0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id    <= pick_id;
                        grant_valid <= 1'b1;
                        wd_cnt      <= '0;
                        state       <= XFER;
                    end
                end
                XFER: begin
                    if (handshake) begin
                        wd_cnt <= '0;
                        if (sel_last) begin
                            last_id     <= grant_id;
                            grant_valid <= 1'b0;
                            state       <= IDLE;
                        end
                    end else if (wd_expired && !full) begin
                        timeout     <= 1'b1;
                        last_id     <= grant_id;
                        grant_valid <= 1'b0;
                        wd_cnt      <= '0;
                        state       <= IDLE;
                    end else if (wd_tick) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
